tx_hex_sender: RTL and testbench



---
 rtl/tx_hex_sender_pkg.sv | 14 +
 rtl/tx_hex_sender_nibble_to_ascii.sv | 15 +
 rtl/tx_hex_sender.sv | 54 +++++
 tb/tb_tx_hex_sender.sv | 110 +++++++++++
 4 files changed

// File: rtl/tx_hex_sender_pkg.sv
// tx_hex_pkg: state encoding and ASCII constants shared by the hex sender.
// The CR/LF states exist in the encoding even when TX_HEX_CRLF_EN is not defined.
package tx_hex_pkg;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HI   = 3'd1;
   localparam logic [2:0] LO   = 3'd2;
   localparam logic [2:0] CR   = 3'd3;
   localparam logic [2:0] LF   = 3'd4;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A_UP = 8'h41;
   localparam logic [7:0] ASCII_A_LO = 8'h61;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
endpackage

// File: rtl/tx_hex_sender_nibble_to_ascii.sv
// nibble_to_ascii: combinational 4-bit nibble to ASCII hex character.
// Ports: nibble (4-bit in), char (8-bit ASCII out).
// HEX_UPPER selects the case of the letters 'A'-'F'.
module nibble_to_ascii
   import tx_hex_pkg::*;
#(
   parameter bit HEX_UPPER = 1'b1
) (
   input  logic [3:0] nibble,
   output logic [7:0] char
);
   localparam logic [7:0] ASCII_A = HEX_UPPER ? ASCII_A_UP : ASCII_A_LO;
   always_comb
      char = nibble < 4'd10 ? ASCII_0 + {4'h0, nibble} : ASCII_A + {4'h0, nibble} - 8'd10;
endmodule

// File: rtl/tx_hex_sender.sv
// tx_hex_sender: writes a latched byte to the UART TX FIFO as two ASCII hex characters.
// Ports: clk, reset (sync, active-high), start/data_in (request + byte),
//        tx_full (FIFO full), wr_uart/w_data (FIFO write port),
//        busy (transfer in progress), overrun (sticky start-while-busy), led0 (= tx_full).
// Define TX_HEX_CRLF_EN to append CR and LF after the two hex characters.
module tx_hex_sender
   import tx_hex_pkg::*;
#(
   parameter bit HEX_UPPER = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic       busy,
   output logic       overrun,
   output logic       led0
);
   logic [2:0] state, next_state;
   logic [7:0] byte_q, hi_c, lo_c;
   nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_hi (.nibble(byte_q[7:4]), .char(hi_c));
   nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_lo (.nibble(byte_q[3:0]), .char(lo_c));
   assign busy    = state != IDLE;
   assign wr_uart = busy && !tx_full && !reset;
   assign led0    = tx_full;
   always_comb begin
`ifdef TX_HEX_CRLF_EN
      next_state = state == HI ? LO : state == LO ? CR : state == CR ? LF : IDLE;
      w_data     = state == HI ? hi_c : state == LO ? lo_c :
                   state == CR ? ASCII_CR : state == LF ? ASCII_LF : 8'h00;
`else
      next_state = state == HI ? LO : IDLE;
      w_data     = state == HI ? hi_c : state == LO ? lo_c : 8'h00;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         byte_q  <= 8'h00;
         overrun <= 1'b0;
      end else if (!busy) begin
         if (start) begin
            byte_q <= data_in;
            state  <= HI;
         end
      end else begin
         if (start) overrun <= 1'b1;
         if (wr_uart) state <= next_state;
      end
   end
endmodule

// File: tb/tb_tx_hex_sender.sv
// tb_tx_hex_sender: randomized bench for tx_hex_sender against a character-queue model.
module tb_tx_hex_sender;
   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, tx_full = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       wr_up, wr_lo, busy_up, busy_lo, ov_up, ov_lo, led_up, led_lo;
   logic [7:0] wd_up, wd_lo;
   int         n_cmp = 0, n_err = 0;
   int         q[$];
   bit         ov = 1'b0, known = 1'b0;

   always #5 clk = ~clk;

   tx_hex_sender #(.HEX_UPPER(1'b1)) dut_up (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .tx_full(tx_full),
      .wr_uart(wr_up), .w_data(wd_up), .busy(busy_up), .overrun(ov_up), .led0(led_up));
   tx_hex_sender #(.HEX_UPPER(1'b0)) dut_lo (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in), .tx_full(tx_full),
      .wr_uart(wr_lo), .w_data(wd_lo), .busy(busy_lo), .overrun(ov_lo), .led0(led_lo));

   task automatic check(string tag, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Queue entries: 0..15 are nibbles, 256+code are literal characters.
   function automatic logic [7:0] chr(int t, bit up);
      if (t >= 256) return 8'(t - 256);
      if (t < 10) return 8'(48 + t);
      return 8'((up ? 65 : 97) + t - 10);
   endfunction

   task automatic cycle(bit st, logic [7:0] d, bit full, bit rst);
      bit b, w;
      logic [7:0] c_up, c_lo;
      @(negedge clk);
      start = st; data_in = d; tx_full = full; reset = rst;
      #1;
      b = q.size() != 0;
      w = b && !full && !rst;
      c_up = 8'h00;
      c_lo = 8'h00;
      if (b) begin
         c_up = chr(q[0], 1'b1);
         c_lo = chr(q[0], 1'b0);
      end
      if (known) begin
         check("wr_uart_up", {7'd0, wr_up}, {7'd0, w});
         check("wr_uart_lo", {7'd0, wr_lo}, {7'd0, w});
         check("w_data_up", wd_up, c_up);
         check("w_data_lo", wd_lo, c_lo);
         check("busy_up", {7'd0, busy_up}, {7'd0, b});
         check("busy_lo", {7'd0, busy_lo}, {7'd0, b});
         check("overrun_up", {7'd0, ov_up}, {7'd0, ov});
         check("overrun_lo", {7'd0, ov_lo}, {7'd0, ov});
         check("led0", {7'd0, led_up}, {7'd0, full});
      end
      if (rst) begin
         q.delete();
         ov = 1'b0;
         known = 1'b1;
      end else if (b) begin
         if (st) ov = 1'b1;
         if (w) void'(q.pop_front());
      end else if (st) begin
         q.push_back(int'(d[7:4]));
         q.push_back(int'(d[3:0]));
`ifdef TX_HEX_CRLF_EN
         q.push_back(256 + 13);
         q.push_back(256 + 10);
`endif
      end
   endtask

   task automatic send(logic [7:0] d);
      cycle(1'b1, d, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      send(8'h3A);
      send(8'h07);
      send(8'hBF);
      send(8'h00);
      send(8'hFF);
      cycle(1'b1, 8'hC5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h12, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 8'h34, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      send(8'h34);
      for (int i = 0; i < 6; i++) cycle(q.size() == 0, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b1, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(3) == 0, 8'($urandom), $urandom_range(3) == 0, $urandom_range(99) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
